// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: operand forwarding, load-use bubble,
// control flush, memory-wait freeze with timeout flag and stall performance counter.
//
// state | meaning
// RUN   | memory idle or ready, pipeline advancing
// WAIT  | MEM-stage access outstanding, pipeline frozen
module pipeline_hazard_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_reg,
    input  logic             id_is_load,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_req,
    input  logic             MIO_ready,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, WAIT} waitState_t;

    localparam logic [7:0] WAIT_LIMIT8 = 8'(WAIT_LIMIT);

    waitState_t       state, stateNext;
    logic [7:0]       waitCnt, waitCntNext;
    logic             timeoutQ;
    logic [CNT_W-1:0] stallCnt;

    logic       exWrEn, exIsLoad, memWrEn, memIsLoad;
    logic [4:0] exWrReg, memWrReg;
    logic       loadUse, freeze;

    // EX wins over MEM; a load still in EX has no data yet, so it is never an EX source.
    function automatic logic [1:0] fwdSel(
        input logic       useReg,
        input logic [4:0] srcReg,
        input logic       exEn,
        input logic [4:0] exReg,
        input logic       exLd,
        input logic       memEn,
        input logic [4:0] memReg,
        input logic       memLd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (useReg && srcReg != 5'd0) begin
            if (exEn && exReg == srcReg && !exLd) begin
                sel = 2'b01;
            end else if (memEn && memReg == srcReg) begin
                sel = memLd ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    assign fwd_rs = fwdSel(id_use_rs, id_rs, exWrEn, exWrReg, exIsLoad,
                           memWrEn, memWrReg, memIsLoad);
    assign fwd_rt = fwdSel(id_use_rt, id_rt, exWrEn, exWrReg, exIsLoad,
                           memWrEn, memWrReg, memIsLoad);

    assign loadUse = exIsLoad && exWrEn && exWrReg != 5'd0 &&
                     ((id_use_rs && id_rs == exWrReg) || (id_use_rt && id_rt == exWrReg));

    assign freeze = mem_req & ~MIO_ready;

    always_comb begin
        pipe_freeze  = freeze;
        pc_stall     = freeze | loadUse;
        if_id_stall  = freeze | loadUse;
        id_ex_bubble = loadUse & ~freeze;
        if_id_flush  = (branch_taken | jump) & ~loadUse & ~freeze;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exWrEn    <= 1'b0;
            exWrReg   <= 5'd0;
            exIsLoad  <= 1'b0;
            memWrEn   <= 1'b0;
            memWrReg  <= 5'd0;
            memIsLoad <= 1'b0;
        end else if (!freeze) begin
            memWrEn   <= exWrEn;
            memWrReg  <= exWrReg;
            memIsLoad <= exIsLoad;
            if (id_ex_bubble) begin
                exWrEn   <= 1'b0;
                exWrReg  <= 5'd0;
                exIsLoad <= 1'b0;
            end else begin
                exWrEn   <= id_wr_en;
                exWrReg  <= id_wr_reg;
                exIsLoad <= id_is_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            RUN: begin
                waitCntNext = 8'd0;
                if (freeze) stateNext = WAIT;
            end
            WAIT: begin
                if (freeze) begin
                    if (waitCnt != 8'hFF) waitCntNext = waitCnt + 8'd1;
                end else begin
                    stateNext = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt  <= 8'd0;
            timeoutQ <= 1'b0;
            stallCnt <= '0;
        end else begin
            waitCnt <= waitCntNext;
            if (state == WAIT && freeze && waitCntNext == WAIT_LIMIT8) timeoutQ <= 1'b1;
            if ((pc_stall || freeze) && !(&stallCnt)) stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign mem_timeout = timeoutQ;
    assign stall_count = stallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected outputs are queued as each cycle's
// stimulus is driven and popped for comparison on the following falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_wr_reg;
    logic        id_use_rs, id_use_rt, id_wr_en, id_is_load;
    logic        branch_taken, jump, mem_req, MIO_ready;
    logic [1:0]  fwd_rs, fwd_rt;
    logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze, mem_timeout;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WAIT_LIMIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .jump(jump), .mem_req(mem_req), .MIO_ready(MIO_ready),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    typedef struct {
        string      tag;
        logic [1:0] fRs, fRt;
        logic       stall, bubble, flush, freeze, tmo;
        int         cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = 5'd0; id_is_load = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; mem_req = 1'b0; MIO_ready = 1'b0;
    endtask

    // Push the expectation for the inputs just driven, then compare at the falling edge.
    task automatic step(input string tag, input logic [1:0] fRs, input logic [1:0] fRt,
                        input logic stall, input logic bubble, input logic flush,
                        input logic freeze, input logic tmo, input int cnt);
        exp_t e;
        e.tag = tag; e.fRs = fRs; e.fRt = fRt; e.stall = stall; e.bubble = bubble;
        e.flush = flush; e.freeze = freeze; e.tmo = tmo; e.cnt = cnt;
        expQ.push_back(e);
        @(negedge clk);
        e = expQ.pop_front();
        checkVal({e.tag, "/fwd_rs"},       32'(fwd_rs),       32'(e.fRs));
        checkVal({e.tag, "/fwd_rt"},       32'(fwd_rt),       32'(e.fRt));
        checkVal({e.tag, "/pc_stall"},     32'(pc_stall),     32'(e.stall));
        checkVal({e.tag, "/if_id_stall"},  32'(if_id_stall),  32'(e.stall));
        checkVal({e.tag, "/id_ex_bubble"}, 32'(id_ex_bubble), 32'(e.bubble));
        checkVal({e.tag, "/if_id_flush"},  32'(if_id_flush),  32'(e.flush));
        checkVal({e.tag, "/pipe_freeze"},  32'(pipe_freeze),  32'(e.freeze));
        checkVal({e.tag, "/mem_timeout"},  32'(mem_timeout),  32'(e.tmo));
        checkVal({e.tag, "/stall_count"},  32'(stall_count),  32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // forwarding from EX, then MEM, and never for $0 or unused operands
        idle(); id_wr_en = 1; id_wr_reg = 5'd3;
        step("add3", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_rs = 5'd3; id_use_rs = 1; id_rt = 5'd4; id_use_rt = 1; id_wr_en = 1; id_wr_reg = 5'd6;
        step("fwd_ex", 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_rs = 5'd3; id_use_rs = 1;
        step("fwd_mem", 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_wr_en = 1; id_wr_reg = 5'd0;
        step("wr0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_use_rs = 1; id_use_rt = 1;
        step("fwd_r0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_wr_en = 1; id_wr_reg = 5'd7;
        step("add7", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_rs = 5'd7; id_rt = 5'd7; id_use_rt = 1;
        step("fwd_unused", 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);

        // load-use: one bubble, then memory-data forward
        idle(); id_wr_en = 1; id_wr_reg = 5'd5; id_is_load = 1;
        step("lw5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(); id_rt = 5'd5; id_use_rt = 1; id_wr_en = 1; id_wr_reg = 5'd8;
        step("load_use", 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);
        step("after_lu", 2'b00, 2'b11, 0, 0, 0, 0, 0, 1);

        // control flush, and stall beating a branch
        idle(); branch_taken = 1;
        step("branch", 2'b00, 2'b00, 0, 0, 1, 0, 0, 1);
        idle(); id_wr_en = 1; id_wr_reg = 5'd9; id_is_load = 1;
        step("lw9", 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
        idle(); branch_taken = 1; id_rs = 5'd9; id_use_rs = 1;
        step("br_lu", 2'b00, 2'b00, 1, 1, 0, 0, 0, 1);
        step("br_retry", 2'b11, 2'b00, 0, 0, 1, 0, 0, 2);
        idle(); jump = 1;
        step("jump", 2'b00, 2'b00, 0, 0, 1, 0, 0, 2);

        // memory wait: three frozen cycles, shadow state holds
        idle(); id_wr_en = 1; id_wr_reg = 5'd10;
        step("add10", 2'b00, 2'b00, 0, 0, 0, 0, 0, 2);
        idle(); id_rs = 5'd10; id_use_rs = 1; mem_req = 1;
        step("frz1", 2'b01, 2'b00, 1, 0, 0, 1, 0, 2);
        branch_taken = 1;
        step("frz2", 2'b01, 2'b00, 1, 0, 0, 1, 0, 3);
        step("frz3", 2'b01, 2'b00, 1, 0, 0, 1, 0, 4);
        branch_taken = 0; MIO_ready = 1;
        step("ready", 2'b01, 2'b00, 0, 0, 0, 0, 0, 5);
        idle(); id_rs = 5'd10; id_use_rs = 1;
        step("post_frz", 2'b10, 2'b00, 0, 0, 0, 0, 0, 5);

        // timeout after the 5th frozen edge with WAIT_LIMIT=4, sticky afterwards
        idle(); mem_req = 1;
        for (int i = 0; i < 6; i++) step("tmo_wait", 2'b00, 2'b00, 1, 0, 0, 1, i >= 5, 5 + i);
        MIO_ready = 1;
        step("tmo_ready", 2'b00, 2'b00, 0, 0, 0, 0, 1, 11);
        idle();
        step("tmo_sticky", 2'b00, 2'b00, 0, 0, 0, 0, 1, 11);

        // reset in the middle of a wait
        idle(); id_wr_en = 1; id_wr_reg = 5'd12;
        step("add12", 2'b00, 2'b00, 0, 0, 0, 0, 1, 11);
        idle(); id_rs = 5'd12; id_use_rs = 1; mem_req = 1;
        step("pre_rst1", 2'b01, 2'b00, 1, 0, 0, 1, 1, 11);
        step("pre_rst2", 2'b01, 2'b00, 1, 0, 0, 1, 1, 12);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(); id_rs = 5'd12; id_use_rs = 1;
        step("rst_mid_wait", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // wait counter restarts from zero after reset
        idle(); mem_req = 1;
        for (int i = 0; i < 6; i++) step("tmo_after_rst", 2'b00, 2'b00, 1, 0, 0, 1, i >= 5, i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline around the ID-stage decoder.
- Keeps a shadow copy of the EX and MEM stage destination information and uses it to produce the rs/rt forwarding selects.
- Detects load-use hazards and inserts one bubble; kills the fetched instruction on a taken branch or jump.
- Freezes the whole pipeline while memory has not asserted MIO_ready. Also keeps a memory-timeout flag and a stall performance counter.

Parameters:
- WAIT_LIMIT, 255: number of consecutive frozen cycles after which mem_timeout sets.
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_wr_en  in  1  ID instruction writes the register file.
- id_wr_reg  in  5  destination register of the ID instruction (rt, rd or 31 for jal).
- id_is_load  in  1  ID instruction is lw.
- branch_taken  in  1  branch resolved taken in ID.
- jump  in  1  j/jal/jr in ID.
- mem_req  in  1  the MEM-stage instruction accesses memory.
- MIO_ready  in  1  memory has completed the access this cycle.
- fwd_rs  out  2  rs operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM memory data.
- fwd_rt  out  2  rt operand select, same encoding as fwd_rs.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_ex_bubble  out  1  load NOP into ID/EX.
- if_id_flush  out  1  clear IF/ID.
- pipe_freeze  out  1  hold every pipeline register.
- mem_timeout  out  1  sticky memory-timeout error.
- stall_count  out  CNT_W  cycles in which any stall or freeze was active.

Behaviour:
- Shadow state: ex_wr_en, ex_wr_reg, ex_is_load, mem_wr_en, mem_wr_reg, mem_is_load.
  - Each rising clk with pipe_freeze=0: MEM <= EX; EX <= ID inputs.
  - If id_ex_bubble=1, EX <= zeros (NOP) instead of the ID inputs.
  - With pipe_freeze=1 the shadow state holds.
- Forwarding is combinational, per operand (rs shown; rt identical using id_rt):
  - If the operand is used, the register is nonzero, ex_wr_en=1, ex_wr_reg matches and ex_is_load=0 -> 01.
  - Else if mem_wr_en=1 and mem_wr_reg matches -> 10, or 11 when mem_is_load=1.
  - Else 00.
  - EX has priority over MEM.
  - Register 0 is never forwarded.
  - An unused operand always gives 00.
- Load-use hazard:
  - load_use = ex_is_load & ex_wr_en & ex_wr_reg!=0 & ((id_use_rs & id_rs==ex_wr_reg) | (id_use_rt & id_rt==ex_wr_reg)).
  - load_use drives pc_stall=1, if_id_stall=1 and id_ex_bubble=1 for exactly one cycle.
  - In the following cycle the load is in MEM and forwarding returns 11.
- Control flush: if_id_flush = (branch_taken | jump) & ~load_use & ~pipe_freeze.
  - If load_use and a branch occur together, the stall wins and the branch re-resolves in the next cycle with forwarded operands.
- Memory wait FSM, states RUN and WAIT:
  - pipe_freeze = mem_req & ~MIO_ready, combinational in every state.
  - RUN -> WAIT when pipe_freeze=1. WAIT -> RUN when pipe_freeze=0.
  - wait_cnt (8 bits): cleared in RUN. Incremented in WAIT while pipe_freeze=1, saturating at 255.
  - mem_timeout sets when wait_cnt reaches WAIT_LIMIT and stays set until rst.
  - While pipe_freeze=1: pc_stall and if_id_stall are forced 1, id_ex_bubble and if_id_flush are forced 0, and load_use is not acted on.
- stall_count: increments by 1 on every clk where pc_stall|pipe_freeze=1. Saturates at all-ones, no wrap.
- Reset (rst=1 at a clk edge), including mid-wait:
  - Shadow state cleared to zero.
  - FSM -> RUN, wait_cnt=0, mem_timeout=0, stall_count=0.
  - After reset, with idle inputs, all outputs are 0.
- Latency: all hazard outputs are combinational from inputs plus registered shadow state, i.e. same cycle. Counters and flags update on the next edge.

Test Plan:
- Forwarding: ID add $3 then ID sub using rs=$3 in the next cycle -> fwd_rs=01. Two cycles later -> 10. Same test with rd=$0 -> fwd_rs=00.
- Load-use: lw $5 in EX, ID reads rt=$5 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_bubble=1. Next cycle fwd_rt=11, stall=0. stall_count=1.
- Branch: branch_taken=1, no hazard -> if_id_flush=1 for one cycle. branch_taken=1 with load_use -> flush=0, stall=1.
- Memory wait: mem_req=1 with MIO_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, shadow state unchanged, stall_count=3. When MIO_ready rises -> freeze drops in the same cycle.
- Timeout, with WAIT_LIMIT=4: MIO_ready held low -> mem_timeout=1 after the 5th frozen edge. It stays 1 after MIO_ready rises and clears only on rst.
- Reset mid-wait: assert rst during WAIT -> next cycle FSM in RUN, counters 0, fwd_rs=00, fwd_rt=00.
